uart_rx_frame_check: RTL and testbench

- Parametrised successor to the RX start-bit checker; validates a complete UART frame: start, data, optional parity, 1 or 2 stop bits.
- Sits in UART_RX between the data sampler (one `bit_valid` strobe per sampled bit) and the RX output/register interface.
- Tracks frame position itself with an internal FSM.
- Flags start glitch, parity error and stop error; delivers clean bytes; keeps saturating error counters for the register block.

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/sat_counter.sv | 35 +++
 rtl/uart_rx_frame_check.sv | 205 ++++++++++++++++++++
 tb/tb_uart_rx_frame_check.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, parity types and
// the legal parameter ranges of the frame checker.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned DATA_WIDTH_MIN = 5;
  localparam int unsigned DATA_WIDTH_MAX = 9;
  localparam int unsigned STOP_BITS_MIN  = 1;
  localparam int unsigned STOP_BITS_MAX  = 2;

  function automatic bit params_legal(int unsigned data_width, int unsigned stop_bits);
    return (data_width >= DATA_WIDTH_MIN) && (data_width <= DATA_WIDTH_MAX) &&
           (stop_bits >= STOP_BITS_MIN) && (stop_bits <= STOP_BITS_MAX);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear takes priority over a same-cycle increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, else increment unless already all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART RX frame checker: walks start, data, optional parity and stop bits on
// each sampled-bit strobe, reports glitch/parity/stop errors as registered
// pulses, delivers clean data and keeps saturating error counts.
module uart_rx_frame_check
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  abort,
  input  logic                  clr_cnt,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  frame_done,
  output logic                  strt_glitch,
  output logic                  par_err,
  output logic                  stp_err,
  output logic [ERR_CNT_W-1:0]  strt_err_cnt,
  output logic [ERR_CNT_W-1:0]  par_err_cnt,
  output logic [ERR_CNT_W-1:0]  stp_err_cnt
);

  if (!params_legal(DATA_WIDTH, STOP_BITS)) begin : g_param_check
    $error("uart_rx_frame_check: DATA_WIDTH or STOP_BITS out of range");
  end

  localparam logic [3:0] IdxLast  = 4'(DATA_WIDTH - 1);
  localparam logic       StopLast = 1'(STOP_BITS - 1);

  rx_state_e             state_q, state_d;
  logic [3:0]            idx_q, idx_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_bad_q, par_bad_d;
  logic                  stp_bad_q, stp_bad_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic                  strt_glitch_q, strt_glitch_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  par_exp;
  logic                  stop_bad;

  // Parity bit the transmitter should have sent for the assembled data.
  assign par_exp = (^shift_q) ^ (par_typ_q == PAR_ODD);

  // Frame FSM next state, shift register and registered pulse outputs.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    stop_cnt_d    = stop_cnt_q;
    shift_d       = shift_q;
    par_en_d      = par_en_q;
    par_typ_d     = par_typ_q;
    par_bad_d     = par_bad_q;
    stp_bad_d     = stp_bad_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    frame_done_d  = 1'b0;
    strt_glitch_d = 1'b0;
    par_err_d     = 1'b0;
    stp_err_d     = 1'b0;
    stop_bad      = stp_bad_q | ~sampled_bit;

    if (abort) begin
      state_d    = StIdle;
      idx_d      = '0;
      stop_cnt_d = 1'b0;
      par_bad_d  = 1'b0;
      stp_bad_d  = 1'b0;
    end else if (bit_valid) begin
      unique case (state_q)
        StIdle: begin
          if (!sampled_bit) begin
            state_d    = StData;
            idx_d      = '0;
            stop_cnt_d = 1'b0;
            par_en_d   = par_en;
            par_typ_d  = par_typ;
            par_bad_d  = 1'b0;
            stp_bad_d  = 1'b0;
          end else begin
            strt_glitch_d = 1'b1;
          end
        end
        StData: begin
          // LSB-first line order: each bit enters at the top and walks down.
          shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          if (idx_q == IdxLast) begin
            idx_d   = '0;
            state_d = par_en_q ? StParity : StStop;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        StParity: begin
          par_bad_d = (sampled_bit != par_exp);
          state_d   = StStop;
        end
        StStop: begin
          if (stop_cnt_q == StopLast) begin
            state_d      = StIdle;
            stop_cnt_d   = 1'b0;
            par_bad_d    = 1'b0;
            stp_bad_d    = 1'b0;
            frame_done_d = 1'b1;
            par_err_d    = par_bad_q;
            stp_err_d    = stop_bad;
            data_out_d   = shift_q;
            data_valid_d = ~par_bad_q & ~stop_bad;
          end else begin
            stp_bad_d  = stop_bad;
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    busy_d = (state_d != StIdle);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      stop_cnt_q    <= 1'b0;
      shift_q       <= '0;
      par_en_q      <= 1'b0;
      par_typ_q     <= 1'b0;
      par_bad_q     <= 1'b0;
      stp_bad_q     <= 1'b0;
      busy_q        <= 1'b0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      strt_glitch_q <= 1'b0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      stop_cnt_q    <= stop_cnt_d;
      shift_q       <= shift_d;
      par_en_q      <= par_en_d;
      par_typ_q     <= par_typ_d;
      par_bad_q     <= par_bad_d;
      stp_bad_q     <= stp_bad_d;
      busy_q        <= busy_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_done_q  <= frame_done_d;
      strt_glitch_q <= strt_glitch_d;
      par_err_q     <= par_err_d;
      stp_err_q     <= stp_err_d;
    end
  end

  assign busy        = busy_q;
  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_done  = frame_done_q;
  assign strt_glitch = strt_glitch_q;
  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;

  // Counters step on the registered error pulses.
  sat_counter #(.W(ERR_CNT_W)) u_strt_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc (strt_glitch_q),
    .clr (clr_cnt),
    .cnt (strt_err_cnt)
  );

  sat_counter #(.W(ERR_CNT_W)) u_par_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc (par_err_q),
    .clr (clr_cnt),
    .cnt (par_err_cnt)
  );

  sat_counter #(.W(ERR_CNT_W)) u_stp_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc (stp_err_q),
    .clr (clr_cnt),
    .cnt (stp_err_cnt)
  );

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Directed bench for uart_rx_frame_check: one instance with one stop bit and
// one with two stop bits, sharing stimulus except for the bit strobe.
module tb_uart_rx_frame_check;
  import uart_rx_pkg::*;

  logic CLK, RST;
  logic bv, sb, par_en, par_typ, abort, clr_cnt, use2;
  logic bv1, bv2;

  logic       busy1, dv1, fd1, sg1, pe1, se1;
  logic [7:0] dout1, sc1, pc1, ec1;
  logic       busy2, dv2, fd2, sg2, pe2, se2;
  logic [7:0] dout2, sc2, pc2, ec2;

  logic       o_busy, o_dv, o_fd, o_sg, o_pe, o_se;
  logic [7:0] o_dout, o_sc, o_pc, o_ec;

  int tests_run    = 0;
  int tests_failed = 0;

  assign bv1 = bv & ~use2;
  assign bv2 = bv & use2;

  assign o_busy = use2 ? busy2 : busy1;
  assign o_dv   = use2 ? dv2   : dv1;
  assign o_fd   = use2 ? fd2   : fd1;
  assign o_sg   = use2 ? sg2   : sg1;
  assign o_pe   = use2 ? pe2   : pe1;
  assign o_se   = use2 ? se2   : se1;
  assign o_dout = use2 ? dout2 : dout1;
  assign o_sc   = use2 ? sc2   : sc1;
  assign o_pc   = use2 ? pc2   : pc1;
  assign o_ec   = use2 ? ec2   : ec1;

  uart_rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1), .ERR_CNT_W(8)) u_dut1 (
    .CLK          (CLK),
    .RST          (RST),
    .bit_valid    (bv1),
    .sampled_bit  (sb),
    .par_en       (par_en),
    .par_typ      (par_typ),
    .abort        (abort),
    .clr_cnt      (clr_cnt),
    .busy         (busy1),
    .data_out     (dout1),
    .data_valid   (dv1),
    .frame_done   (fd1),
    .strt_glitch  (sg1),
    .par_err      (pe1),
    .stp_err      (se1),
    .strt_err_cnt (sc1),
    .par_err_cnt  (pc1),
    .stp_err_cnt  (ec1)
  );

  uart_rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(2), .ERR_CNT_W(8)) u_dut2 (
    .CLK          (CLK),
    .RST          (RST),
    .bit_valid    (bv2),
    .sampled_bit  (sb),
    .par_en       (par_en),
    .par_typ      (par_typ),
    .abort        (abort),
    .clr_cnt      (clr_cnt),
    .busy         (busy2),
    .data_out     (dout2),
    .data_valid   (dv2),
    .frame_done   (fd2),
    .strt_glitch  (sg2),
    .par_err      (pe2),
    .stp_err      (se2),
    .strt_err_cnt (sc2),
    .par_err_cnt  (pc2),
    .stp_err_cnt  (ec2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_pulses(input string pfx, input logic fd, input logic dv, input logic pe,
                              input logic se, input logic [7:0] data);
    check_eq({pfx, ".frame_done"}, {31'd0, o_fd}, {31'd0, fd});
    check_eq({pfx, ".data_valid"}, {31'd0, o_dv}, {31'd0, dv});
    check_eq({pfx, ".par_err"}, {31'd0, o_pe}, {31'd0, pe});
    check_eq({pfx, ".stp_err"}, {31'd0, o_se}, {31'd0, se});
    check_eq({pfx, ".data_out"}, {24'd0, o_dout}, {24'd0, data});
  endtask

  // Present one sampled bit on the next cycle; the strobe stays high.
  task automatic drive_bit(input logic b);
    @(negedge CLK);
    bv = 1'b1;
    sb = b;
  endtask

  task automatic end_bits();
    @(negedge CLK);
    bv = 1'b0;
  endtask

  // pbit < 0 means no parity bit. Parity config is flipped mid-frame to show
  // that only the value at the start bit matters, then restored.
  task automatic push_frame(input logic [7:0] data, input int pbit, input logic [1:0] stops,
                            input bit skip_start);
    if (!skip_start) drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_bit(data[i]);
      if (i == 0) begin
        par_en  = ~par_en;
        par_typ = ~par_typ;
      end
    end
    if (pbit >= 0) drive_bit(pbit[0]);
    drive_bit(stops[0]);
    if (use2) drive_bit(stops[1]);
    par_en  = ~par_en;
    par_typ = ~par_typ;
  endtask

  initial begin
    RST = 1'b0; bv = 1'b0; sb = 1'b1; par_en = 1'b0; par_typ = PAR_EVEN;
    abort = 1'b0; clr_cnt = 1'b0; use2 = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("rst.busy", {31'd0, o_busy}, 32'd0);
    check_eq("rst.data_out", {24'd0, o_dout}, 32'd0);
    check_eq("rst.strt_cnt", {24'd0, o_sc}, 32'd0);
    check_eq("rst.busy2", {31'd0, busy2}, 32'd0);
    RST = 1'b1;
    @(negedge CLK);

    // Start glitch and counter saturation
    drive_bit(1'b1);
    end_bits();
    check_eq("glitch.pulse", {31'd0, o_sg}, 32'd1);
    check_eq("glitch.busy", {31'd0, o_busy}, 32'd0);
    @(negedge CLK);
    check_eq("glitch.pulse_end", {31'd0, o_sg}, 32'd0);
    check_eq("glitch.cnt1", {24'd0, o_sc}, 32'd1);
    for (int i = 0; i < 299; i++) drive_bit(1'b1);
    end_bits();
    repeat (2) @(negedge CLK);
    check_eq("glitch.cnt_sat", {24'd0, o_sc}, 32'd255);

    // Clean 8N1 frame
    push_frame(8'hA5, -1, 2'b01, 1'b0);
    end_bits();
    check_pulses("8n1", 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
    check_eq("8n1.busy", {31'd0, o_busy}, 32'd0);

    // Parity, even then odd, data 0x07 (three ones)
    par_en = 1'b1; par_typ = PAR_EVEN;
    push_frame(8'h07, 1, 2'b01, 1'b0);
    end_bits();
    check_pulses("even_ok", 1'b1, 1'b1, 1'b0, 1'b0, 8'h07);
    push_frame(8'h07, 0, 2'b01, 1'b0);
    end_bits();
    check_pulses("even_bad", 1'b1, 1'b0, 1'b1, 1'b0, 8'h07);
    @(negedge CLK);
    check_eq("even_bad.cnt", {24'd0, o_pc}, 32'd1);
    par_typ = PAR_ODD;
    push_frame(8'h07, 0, 2'b01, 1'b0);
    end_bits();
    check_pulses("odd_ok", 1'b1, 1'b1, 1'b0, 1'b0, 8'h07);
    push_frame(8'h07, 1, 2'b01, 1'b0);
    end_bits();
    check_pulses("odd_bad", 1'b1, 1'b0, 1'b1, 1'b0, 8'h07);
    @(negedge CLK);
    check_eq("odd_bad.cnt", {24'd0, o_pc}, 32'd2);

    // Single stop bit sampled low
    par_en = 1'b0; par_typ = PAR_EVEN;
    push_frame(8'h3C, -1, 2'b00, 1'b0);
    end_bits();
    check_pulses("stop1_bad", 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C);
    @(negedge CLK);
    check_eq("stop1_bad.cnt", {24'd0, o_ec}, 32'd1);

    // Two stop bits on the second instance
    use2 = 1'b1;
    push_frame(8'h3C, -1, 2'b01, 1'b0);
    end_bits();
    check_pulses("stop2_10", 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C);
    push_frame(8'h81, -1, 2'b11, 1'b0);
    end_bits();
    check_pulses("stop2_11", 1'b1, 1'b1, 1'b0, 1'b0, 8'h81);
    push_frame(8'h42, -1, 2'b10, 1'b0);
    end_bits();
    check_pulses("stop2_01", 1'b1, 1'b0, 1'b0, 1'b1, 8'h42);
    @(negedge CLK);
    check_eq("stop2.cnt", {24'd0, o_ec}, 32'd2);
    use2 = 1'b0;

    // Abort after three data bits
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    @(negedge CLK);
    bv = 1'b0;
    abort = 1'b1;
    check_eq("abort.busy_before", {31'd0, o_busy}, 32'd1);
    @(negedge CLK);
    abort = 1'b0;
    check_eq("abort.busy_after", {31'd0, o_busy}, 32'd0);
    check_pulses("abort", 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C);
    push_frame(8'h5A, -1, 2'b01, 1'b0);
    end_bits();
    check_pulses("post_abort", 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A);

    // Back-to-back frames with no idle cycle between them
    push_frame(8'h12, -1, 2'b01, 1'b0);
    @(negedge CLK);
    check_pulses("b2b_1", 1'b1, 1'b1, 1'b0, 1'b0, 8'h12);
    sb = 1'b0;
    push_frame(8'h34, -1, 2'b01, 1'b1);
    end_bits();
    check_pulses("b2b_2", 1'b1, 1'b1, 1'b0, 1'b0, 8'h34);

    // Clear coincident with a parity error pulse
    par_en = 1'b1; par_typ = PAR_EVEN;
    push_frame(8'h07, 0, 2'b01, 1'b0);
    @(negedge CLK);
    bv = 1'b0;
    clr_cnt = 1'b1;
    check_eq("clr.par_err", {31'd0, o_pe}, 32'd1);
    @(negedge CLK);
    clr_cnt = 1'b0;
    check_eq("clr.par_cnt", {24'd0, o_pc}, 32'd0);
    check_eq("clr.strt_cnt", {24'd0, o_sc}, 32'd0);
    check_eq("clr.stp_cnt", {24'd0, o_ec}, 32'd0);
    @(negedge CLK);
    check_eq("clr.par_cnt_hold", {24'd0, o_pc}, 32'd0);

    // Reset mid-DATA
    par_en = 1'b0;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    #2;
    check_eq("rstmid.busy_before", {31'd0, o_busy}, 32'd1);
    RST = 1'b0;
    #1;
    check_eq("rstmid.busy", {31'd0, o_busy}, 32'd0);
    check_pulses("rstmid", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    bv = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    push_frame(8'hC3, -1, 2'b01, 1'b0);
    end_bits();
    check_pulses("post_rst", 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
